msg_tx_controller: RTL and testbench
====================================

Name: msg_tx_controller

Overview:
- Sequences serial transmission of a MSG_W-bit message captured from the board switches.
- Owns load, framing, bit timing, one-shot/repeat scheduling and stop requests.
- Drives the single serial line `out` that top-level integration observes.
- Sits between the switch/button inputs (init, start, mode, sel, SW) and the serial output pin.

Parameters:
- MSG_W, 10, message width in bits.
- BIT_CYC_SLOW, 4, clocks per bit when sel=0 (≥1).
- BIT_CYC_FAST, 1, clocks per bit when sel=1 (≥1).
- GAP_CYC, 3, idle-high clocks between repeated frames (≥1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- init  in  1  load request: capture SW into message register.
- SW  in  MSG_W  message source.
- start  in  1  single-cycle start pulse; while busy in repeat mode, it is a stop request.
- mode  in  1  0 = one-shot, 1 = repeat until stopped.
- sel  in  1  bit-rate select: 0 = slow, 1 = fast.
- out  out  1  serial line, idle high.
- busy  out  1  high from first start-bit cycle until the last stop-bit (or gap) cycle.
- done  out  1  one-cycle pulse when transmission ends and the block returns to IDLE.

Behaviour:
- Reset (sync, rst=1 at an edge):
  - state=IDLE, msg_reg=0, out=1, busy=0, done=0.
  - All counters and stop_req clear.
  - Mid-frame reset aborts the frame; out=1 on the following cycle.
- Frame format (MSG_W+2 bits, each held BIT_CYC clocks): start bit 0, then msg_reg MSB first, then stop bit 1.
- States: IDLE, SEND, GAP.
- IDLE:
  - init=1 → msg_reg<=SW.
  - start=1 → latch mode_q=mode and bitcyc_q=(sel?BIT_CYC_FAST:BIT_CYC_SLOW), load shift register from msg_reg, go to SEND.
  - If init and start are both high in the same cycle, the frame sends the new SW value (load has priority, then send).
  - Latency: start sampled at edge N → out=0 and busy=1 from edge N+1.
- SEND:
  - Period counter counts bitcyc_q-1..0. At 0 it advances the bit index (0..MSG_W+1) and shifts.
  - At the end of the stop bit:
    - mode_q=0, or stop_req=1 → IDLE, done=1 for one cycle, busy=0 on that same edge.
    - otherwise → GAP.
- GAP:
  - out=1 for GAP_CYC clocks, busy stays 1.
  - Then reload the shift register from msg_reg (not SW) and return to SEND.
- start while busy:
  - mode_q=1 → set stop_req. The current frame always completes, and no further frame follows.
  - mode_q=0 → ignored.
  - stop_req arriving during GAP → exit to IDLE at the end of GAP with done=1, no new frame.
- init while busy: ignored. msg_reg is stable during a transmission.
- mode and sel changes while busy take effect only at the next start from IDLE.
- Width rules:
  - Bit index: $clog2(MSG_W+2) bits.
  - Period counter: $clog2(max(BIT_CYC_SLOW, BIT_CYC_FAST, GAP_CYC)+1) bits.
  - No wrap beyond MSG_W+1.
- out is registered. No combinational path from inputs to out, busy or done.

Decomposition:
- Package msg_tx_pkg:
  - state encoding constants ST_IDLE/ST_SEND/ST_GAP.
  - FRAME_BITS = MSG_W+2.
  - idle-line level constant LINE_IDLE = 1.
- Sub-module bit_timer:
  - Loadable down-counter with a tick output.
  - Used for both bit period and gap timing.
  - Ports: clk, rst, load, load_val, tick.

Test Plan:
1. Reset, then init with SW=10'b1000110101, then start with sel=1, mode=0 → from the next cycle, out = 0,1,0,0,0,1,1,0,1,0,1,1 (one clock each); done pulses after the 12th cycle; busy=0 afterwards.
2. Same message, sel=0 → each bit held exactly 4 clocks, 48 busy cycles, single done pulse.
3. mode=1, sel=1:
   - frame, 3 high gap cycles, identical second frame;
   - start pulse during frame 2 → frame 2 completes, done pulses, no frame 3.
4. init with SW=10'b1111100000 mid-frame of a one-shot send of 10'b1000110101 → current frame unchanged; the next start sends 10'b1000110101 again (init ignored while busy).
5. rst=1 asserted at the 5th bit of a frame → next cycle out=1, busy=0, done=0; subsequent start without init sends 10'b0000000000 (msg_reg cleared).
6. init and start in the same cycle with SW=10'b0101010101 → frame carries 0101010101.

Source files
------------

// File: rtl/msg_tx_pkg.sv
// msg_tx_pkg: shared state type, framing constants and sizing helpers
// for the serial message transmitter.
package msg_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } tx_state_t;

    localparam int unsigned MSG_W_DEF  = 10;
    localparam int unsigned FRAME_BITS = MSG_W_DEF + 2;
    localparam logic        LINE_IDLE  = 1'b1;

    // Start bit + message + stop bit.
    function automatic int unsigned frame_bits(input int unsigned msg_w);
        return msg_w + 2;
    endfunction

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/msg_tx_controller_bit_timer.sv
// bit_timer: loadable down-counter; tick is high while the count sits at zero.
// Times both the bit period and the inter-frame gap.
module bit_timer #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tick
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tick = (count == '0);

endmodule

// File: rtl/msg_tx_controller.sv
// msg_tx_controller: frames the captured switch message (start 0, MSB first,
// stop 1) onto a registered serial line, one-shot or repeating with idle gaps.
module msg_tx_controller
    import msg_tx_pkg::*;
#(
    parameter int unsigned MSG_W        = MSG_W_DEF,
    parameter int unsigned BIT_CYC_SLOW = 4,
    parameter int unsigned BIT_CYC_FAST = 1,
    parameter int unsigned GAP_CYC      = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic [MSG_W-1:0] SW,
    input  logic             start,
    input  logic             mode,
    input  logic             sel,
    output logic             out,
    output logic             busy,
    output logic             done
);

    localparam int unsigned MAX_CYC  = max3(BIT_CYC_SLOW, BIT_CYC_FAST, GAP_CYC);
    localparam int unsigned CNT_W    = $clog2(MAX_CYC + 1);
    localparam int unsigned IDX_W    = $clog2(frame_bits(MSG_W));
    localparam int unsigned LAST_IDX = frame_bits(MSG_W) - 1;

    localparam logic [CNT_W-1:0] SLOW_REL = CNT_W'(BIT_CYC_SLOW - 1);
    localparam logic [CNT_W-1:0] FAST_REL = CNT_W'(BIT_CYC_FAST - 1);
    localparam logic [CNT_W-1:0] GAP_REL  = CNT_W'(GAP_CYC - 1);

    tx_state_t        state, state_nxt;
    logic [MSG_W-1:0] msg_reg;
    logic [MSG_W-1:0] shreg;
    logic [IDX_W-1:0] bit_idx;
    logic [CNT_W-1:0] rel_q;
    logic             mode_q;
    logic             stop_req;

    logic             tick;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             begin_frame;
    logic             advance;
    logic             finish;
    logic             stop_now;

    bit_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .load_val(tmr_val),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A stop pulse on the deciding cycle itself counts, so it never slips a frame.
    always_comb begin
        state_nxt   = state;
        tmr_load    = 1'b0;
        tmr_val     = rel_q;
        begin_frame = 1'b0;
        advance     = 1'b0;
        finish      = 1'b0;
        stop_now    = stop_req | (start & mode_q);
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt   = ST_SEND;
                    begin_frame = 1'b1;
                    tmr_load    = 1'b1;
                    tmr_val     = sel ? FAST_REL : SLOW_REL;
                end
            end
            ST_SEND: begin
                if (tick) begin
                    if (bit_idx == IDX_W'(LAST_IDX)) begin
                        if (!mode_q || stop_now) begin
                            state_nxt = ST_IDLE;
                            finish    = 1'b1;
                        end else begin
                            state_nxt = ST_GAP;
                            tmr_load  = 1'b1;
                            tmr_val   = GAP_REL;
                        end
                    end else begin
                        advance  = 1'b1;
                        tmr_load = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (tick) begin
                    if (stop_now) begin
                        state_nxt = ST_IDLE;
                        finish    = 1'b1;
                    end else begin
                        state_nxt   = ST_SEND;
                        begin_frame = 1'b1;
                        tmr_load    = 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            msg_reg  <= '0;
            shreg    <= '0;
            bit_idx  <= '0;
            rel_q    <= '0;
            mode_q   <= 1'b0;
            stop_req <= 1'b0;
            out      <= LINE_IDLE;
            done     <= 1'b0;
        end else begin
            done <= finish;
            if (state == ST_IDLE) begin
                if (init) begin
                    msg_reg <= SW;
                end
                if (start) begin
                    mode_q <= mode;
                    rel_q  <= sel ? FAST_REL : SLOW_REL;
                end
            end
            // Same-cycle init+start sends the fresh switch value.
            if (begin_frame) begin
                shreg   <= (state == ST_IDLE && init) ? SW : msg_reg;
                bit_idx <= '0;
                out     <= 1'b0;
            end
            if (advance) begin
                bit_idx <= bit_idx + 1'b1;
                if (bit_idx == IDX_W'(LAST_IDX - 1)) begin
                    out <= LINE_IDLE;
                end else begin
                    out   <= shreg[MSG_W-1];
                    shreg <= shreg << 1;
                end
            end
            if (state_nxt == ST_IDLE) begin
                stop_req <= 1'b0;
            end else if (state != ST_IDLE && start && mode_q) begin
                stop_req <= 1'b1;
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_msg_tx_controller.sv
// tb_msg_tx_controller: directed and randomized transmissions checked against
// a waveform model built from the frame/gap/stop rules.
module tb_msg_tx_controller;
    import msg_tx_pkg::*;

    localparam int unsigned W    = 10;
    localparam int unsigned SLOW = 4;
    localparam int unsigned FAST = 1;
    localparam int unsigned GAP  = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         init = 1'b0;
    logic [W-1:0] SW = '0;
    logic         start = 1'b0;
    logic         mode = 1'b0;
    logic         sel = 1'b0;
    logic         out;
    logic         busy;
    logic         done;

    int tests = 0;
    int fails = 0;

    logic         cap[$];
    logic         exp_q[$];
    logic [W-1:0] model_msg;
    int           early_done;

    msg_tx_controller #(
        .MSG_W       (W),
        .BIT_CYC_SLOW(SLOW),
        .BIT_CYC_FAST(FAST),
        .GAP_CYC     (GAP)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .init (init),
        .SW   (SW),
        .start(start),
        .mode (mode),
        .sel  (sel),
        .out  (out),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // Expected line level over every busy cycle of one transaction.
    task automatic build_exp(input logic [W-1:0] msg, input int bc, input bit m, input int stop_at);
        logic frame[$];
        int   len, per, fl;
        frame.delete();
        for (int b = 0; b < int'(FRAME_BITS); b++) begin
            logic v;
            if (b == 0) v = 1'b0;
            else if (b == int'(FRAME_BITS) - 1) v = LINE_IDLE;
            else v = msg[W - b];
            for (int k = 0; k < bc; k++) frame.push_back(v);
        end
        fl  = frame.size();
        per = fl + int'(GAP);
        if (!m) len = fl;
        else if ((stop_at % per) < fl) len = (stop_at / per) * per + fl;
        else len = (stop_at / per + 1) * per;
        exp_q.delete();
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(((i % per) < fl) ? frame[i % per] : LINE_IDLE);
        end
    endtask

    // pre_init: 0 none, 1 init the cycle before start, 2 init with start.
    task automatic run_tx(input string tag, input logic [W-1:0] sw, input int pre_init,
                          input bit s, input bit m, input int stop_at,
                          input int init_at, input logic [W-1:0] init_sw);
        int bad;
        if (pre_init == 1) begin
            @(negedge clk);
            SW = sw; init = 1'b1;
            model_msg = sw;
        end
        @(negedge clk);
        SW = sw; init = (pre_init == 2); start = 1'b1; mode = m; sel = s;
        if (pre_init == 2) model_msg = sw;
        build_exp(model_msg, s ? int'(FAST) : int'(SLOW), m, stop_at);
        @(negedge clk);
        init = 1'b0; start = 1'b0;
        cap.delete();
        early_done = 0;
        for (int c = 0; c < 400; c++) begin
            if (!busy) break;
            cap.push_back(out);
            if (done) early_done++;
            start = (c == stop_at);
            init  = (c == init_at);
            if (c == init_at) SW = init_sw;
            mode  = $urandom_range(0, 1);
            sel   = $urandom_range(0, 1);
            @(negedge clk);
        end
        start = 1'b0; init = 1'b0;
        check({tag, " busy_len"}, cap.size(), exp_q.size());
        bad = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= cap.size() || cap[i] !== exp_q[i]) begin
                bad = i;
                break;
            end
        end
        tests++;
        assert (bad == -1) else begin
            fails++;
            $error("FAIL %s wave: first diff at cycle %0d got %b expected %b", tag, bad,
                   (bad < cap.size()) ? cap[bad] : 1'bx, exp_q[bad]);
        end
        check({tag, " done_early"}, early_done, 0);
        check({tag, " done_pulse"}, int'(done), 1);
        check({tag, " idle_out"}, int'(out), 1);
        @(negedge clk);
        check({tag, " done_single"}, int'(done), 0);
        check({tag, " busy_after"}, int'(busy), 0);
    endtask

    initial begin
        int per_fast, per_slow;
        per_fast = int'(FRAME_BITS * FAST + GAP);
        per_slow = int'(FRAME_BITS * SLOW + GAP);
        model_msg = '0;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset out", int'(out), 1);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);

        run_tx("t1 fast", 10'b1000110101, 1, 1'b1, 1'b0, -1, -1, '0);
        run_tx("t2 slow", 10'b1000110101, 1, 1'b0, 1'b0, -1, -1, '0);
        run_tx("t3 repeat", 10'b1000110101, 0, 1'b1, 1'b1, per_fast + 5, -1, '0);
        run_tx("t3 stop_gap", 10'b1000110101, 0, 1'b1, 1'b1, per_fast + 13, -1, '0);
        run_tx("t4 busy_init", 10'b1000110101, 1, 1'b0, 1'b0, -1, 10, 10'b1111100000);
        run_tx("t4 resend", 10'b0, 0, 1'b1, 1'b0, -1, -1, '0);
        run_tx("t1 stop_ignored", 10'b0, 0, 1'b0, 1'b0, 7, -1, '0);

        // Reset landing on the fifth bit of a fast frame.
        @(negedge clk);
        start = 1'b1; sel = 1'b1; mode = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("t5 mid_busy", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_msg = '0;
        check("t5 rst out", int'(out), 1);
        check("t5 rst busy", int'(busy), 0);
        check("t5 rst done", int'(done), 0);
        run_tx("t5 cleared", 10'b1111111111, 0, 1'b1, 1'b0, -1, -1, '0);

        run_tx("t6 same_cycle", 10'b0101010101, 2, 1'b1, 1'b0, -1, -1, '0);

        for (int n = 0; n < 8; n++) begin
            logic [W-1:0] rmsg;
            bit           rs, rm;
            int           pi, st;
            rmsg = W'($urandom);
            rs   = 1'($urandom_range(0, 1));
            rm   = 1'($urandom_range(0, 1));
            pi   = $urandom_range(0, 2);
            st   = $urandom_range(0, 3 * (rs ? per_fast : per_slow) - 1);
            run_tx($sformatf("rnd%0d", n), rmsg, pi, rs, rm, st, -1, '0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
